// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_send transmitter among N_REQ byte producers.
// Round-robin grant per packet, DATA/DATA_READY handshake per byte, and an
// abort if the transmitter never takes a byte while it reports idle.
//
// state | meaning
// ------+----------------------------------------------------------------
// ARB   | pick the next requester round-robin once the transmitter is idle
// START | byte presented on TX_DATA with TX_DATA_READY high, await accept
// DONE  | byte accepted, waiting for the transmitter to return to idle
// HOLD  | mid-packet, grant locked to the current owner for its next byte
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [8*N_REQ-1:0] REQ_DATA,
  input  logic [N_REQ-1:0]   REQ_VALID,
  input  logic [N_REQ-1:0]   REQ_LAST,
  output logic [N_REQ-1:0]   REQ_READY,
  output logic [7:0]         TX_DATA,
  output logic               TX_DATA_READY,
  input  logic               TX_IDLE,
  output logic [N_REQ-1:0]   GRANT,
  output logic               BUSY,
  output logic               TIMEOUT_ERR
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  // The counter reaches ACK_TIMEOUT on the edge where it currently holds this value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_START = 2'd1,
    ST_DONE  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] cnt;
  logic             last_q;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] sel_idx;
  logic [7:0]       sel_data;
  logic             sel_last;
  logic             xfer;
  logic [PTR_W-1:0] next_ptr;

  // Modulo-N_REQ add; operands are already below N_REQ so one subtract suffices
  // and non-power-of-2 counts wrap correctly.
  function automatic logic [PTR_W-1:0] idx_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PTR_W'(sum);
  endfunction

  // Round-robin search: first valid requester at or after ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && REQ_VALID[idx_add(ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = idx_add(ptr, k);
      end
    end
  end

  // Ready goes to the arbitration winner in ARB or to the locked owner in HOLD;
  // held low during reset so no byte is consumed that the reset would drop.
  always_comb begin
    REQ_READY = '0;
    if (!RST) begin
      if (state == ST_ARB) begin
        if (win_found && TX_IDLE) REQ_READY[win_idx] = 1'b1;
      end else if (state == ST_HOLD) begin
        REQ_READY[owner] = TX_IDLE;
      end
    end
  end

  // Byte/last mux for whichever requester can transfer this cycle.
  always_comb begin
    sel_idx  = (state == ST_HOLD) ? owner : win_idx;
    sel_data = REQ_DATA[8*int'(sel_idx) +: 8];
    sel_last = REQ_LAST[sel_idx];
    xfer     = |(REQ_VALID & REQ_READY);
    next_ptr = idx_add(owner, 1);
  end

  assign BUSY = (state != ST_ARB);

  // Sequencer: grant, present byte, wait for accept and completion, release.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_ARB;
      ptr           <= '0;
      owner         <= '0;
      cnt           <= '0;
      last_q        <= 1'b0;
      TX_DATA       <= '0;
      TX_DATA_READY <= 1'b0;
      GRANT         <= '0;
      TIMEOUT_ERR   <= 1'b0;
    end else begin
      TIMEOUT_ERR <= 1'b0;
      case (state)
        ST_ARB: begin
          if (xfer) begin
            TX_DATA       <= sel_data;
            TX_DATA_READY <= 1'b1;
            GRANT         <= ONE_HOT0 << win_idx;
            owner         <= win_idx;
            last_q        <= sel_last;
            cnt           <= '0;
            state         <= ST_START;
          end
        end
        ST_START: begin
          // Accept takes priority over the timeout on the same cycle.
          if (!TX_IDLE) begin
            TX_DATA_READY <= 1'b0;
            cnt           <= '0;
            state         <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            TX_DATA_READY <= 1'b0;
            cnt           <= '0;
            TIMEOUT_ERR   <= 1'b1;
            GRANT         <= '0;
            ptr           <= next_ptr;
            state         <= ST_ARB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (TX_IDLE) begin
            if (last_q) begin
              GRANT <= '0;
              ptr   <= next_ptr;
              state <= ST_ARB;
            end else begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (xfer) begin
            TX_DATA       <= sel_data;
            TX_DATA_READY <= 1'b1;
            last_q        <= sel_last;
            cnt           <= '0;
            state         <= ST_START;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized rounds,
// checked against a packet-level round-robin model and a uart_send model.
module tb_uart_tx_arbiter;

  localparam int N      = 4;
  localparam int ACK_TO = 8;
  localparam int DEPTH  = 16;

  logic           CLK = 1'b0;
  logic           RST;
  logic [8*N-1:0] REQ_DATA;
  logic [N-1:0]   REQ_VALID;
  logic [N-1:0]   REQ_LAST;
  logic [N-1:0]   REQ_READY;
  logic [7:0]     TX_DATA;
  logic           TX_DATA_READY;
  logic           TX_IDLE;
  logic [N-1:0]   GRANT;
  logic           BUSY;
  logic           TIMEOUT_ERR;

  uart_tx_arbiter #(.N_REQ(N), .ACK_TIMEOUT(ACK_TO)) dut (
    .CLK(CLK), .RST(RST), .REQ_DATA(REQ_DATA), .REQ_VALID(REQ_VALID),
    .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY), .TX_DATA(TX_DATA),
    .TX_DATA_READY(TX_DATA_READY), .TX_IDLE(TX_IDLE), .GRANT(GRANT),
    .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Producer byte lists
  logic [7:0] src_data [N][DEPTH];
  logic       src_last [N][DEPTH];
  int         src_head [N];
  int         src_cnt  [N];

  // uart_send model state
  logic u_idle;
  int   u_seen, u_left, ack_dly, frame_len;
  bit   rand_timing;

  logic [7:0] sent_q[$];
  int         grant_log[$];
  logic [7:0] exp_bytes[$];
  int         exp_grants[$];

  int         n_xfer[N];
  int         rdy_hi[N];
  int         dr_run, dr_max_run, terr_cyc;
  logic [N-1:0] hs, prev_grant;
  logic       prev_dr;
  logic [7:0] prev_data;
  int         n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      if (src_head[i] < src_cnt[i]) begin
        REQ_VALID[i]      = 1'b1;
        REQ_DATA[8*i +: 8] = src_data[i][src_head[i]];
        REQ_LAST[i]       = src_last[i][src_head[i]];
      end else begin
        REQ_VALID[i]      = 1'b0;
        REQ_DATA[8*i +: 8] = 8'h00;
        REQ_LAST[i]       = 1'b0;
      end
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    src_data[r][src_cnt[r]] = d;
    src_last[r][src_cnt[r]] = l;
    src_cnt[r]++;
  endtask

  task automatic clear_logs();
    sent_q.delete();
    grant_log.delete();
    exp_bytes.delete();
    exp_grants.delete();
  endtask

  task automatic clear_test();
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0;
      src_cnt[i]  = 0;
      n_xfer[i]   = 0;
      rdy_hi[i]   = 0;
    end
    clear_logs();
    terr_cyc    = 0;
    dr_run      = 0;
    dr_max_run  = 0;
    rand_timing = 0;
    ack_dly     = 2;
    frame_len   = 10;
    drive_src();
  endtask

  function automatic bit all_consumed();
    for (int i = 0; i < N; i++)
      if (src_head[i] < src_cnt[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: sample handshake before the edge, then update models after it.
  task automatic step();
    #2;
    hs = RST ? '0 : (REQ_VALID & REQ_READY);
    for (int i = 0; i < N; i++) if (REQ_READY[i]) rdy_hi[i]++;
    check_eq("ready_onehot0", 32'($onehot0(REQ_READY)), 1);
    if (TX_DATA_READY) check_eq("ready_in_start", 32'(REQ_READY), 0);
    @(posedge CLK);
    #1;
    if (RST) begin
      u_idle = 1'b1; u_seen = 0; u_left = 0;
    end else if (!u_idle) begin
      u_left--;
      if (u_left <= 0) u_idle = 1'b1;
    end else if (TX_DATA_READY) begin
      u_seen++;
      if (u_seen > ack_dly) begin
        u_idle = 1'b0;
        u_left = frame_len;
        u_seen = 0;
        sent_q.push_back(TX_DATA);
        if (rand_timing) begin
          ack_dly   = int'($urandom_range(0, ACK_TO - 1));
          frame_len = int'($urandom_range(1, 6));
        end
      end
    end else begin
      u_seen = 0;
    end
    TX_IDLE = u_idle;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        src_head[i]++;
        n_xfer[i]++;
      end
    end
    drive_src();
    if (!RST) begin
      check_eq("busy_vs_grant", 32'(BUSY), 32'(GRANT != '0));
      check_eq("grant_onehot0", 32'($onehot0(GRANT)), 1);
      if (TX_DATA_READY && prev_dr) check_eq("data_stable", 32'(TX_DATA), 32'(prev_data));
      if (TIMEOUT_ERR) begin
        terr_cyc++;
        check_eq("terr_grant", 32'(GRANT), 0);
        check_eq("terr_dr", 32'(TX_DATA_READY), 0);
      end
    end
    dr_run = TX_DATA_READY ? dr_run + 1 : 0;
    if (dr_run > dr_max_run) dr_max_run = dr_run;
    if (GRANT != '0 && prev_grant == '0)
      for (int i = 0; i < N; i++) if (GRANT[i]) grant_log.push_back(i);
    prev_grant = GRANT;
    prev_dr    = TX_DATA_READY;
    prev_data  = TX_DATA;
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b1;
    repeat (cycles) step();
    check_eq("rst_tx_data", 32'(TX_DATA), 0);
    check_eq("rst_tx_dr", 32'(TX_DATA_READY), 0);
    check_eq("rst_grant", 32'(GRANT), 0);
    check_eq("rst_busy", 32'(BUSY), 0);
    check_eq("rst_terr", 32'(TIMEOUT_ERR), 0);
    check_eq("rst_ready", 32'(REQ_READY), 0);
    RST = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int  k;
    bit  done;
    k = 0;
    done = 1'b0;
    while (!done && k < budget) begin
      step();
      k++;
      done = !BUSY && u_idle && all_consumed();
    end
    check_eq("drain_in_budget", 32'(done), 1);
  endtask

  task automatic check_stream(input string tag);
    check_eq({tag, "_nbytes"}, 32'(sent_q.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < sent_q.size(); i++)
      check_eq({tag, "_byte"}, 32'(sent_q[i]), 32'(exp_bytes[i]));
    check_eq({tag, "_ngrants"}, 32'(grant_log.size()), 32'(exp_grants.size()));
    for (int i = 0; i < exp_grants.size() && i < grant_log.size(); i++)
      check_eq({tag, "_grant"}, 32'(grant_log[i]), 32'(exp_grants[i]));
  endtask

  // Packet-level reference: whole packets served round-robin from ptr=0,
  // each requester's list consumed in order.
  task automatic model_rr();
    int  head[N];
    int  p;
    bit  any;
    for (int i = 0; i < N; i++) head[i] = 0;
    p = 0;
    exp_bytes.delete();
    exp_grants.delete();
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (p + k) % N;
        if (head[c] < src_cnt[c]) begin
          exp_grants.push_back(c);
          do begin
            exp_bytes.push_back(src_data[c][head[c]]);
            head[c]++;
          end while (head[c] < src_cnt[c] && !src_last[c][head[c]-1]);
          p   = (c + 1) % N;
          any = 1'b1;
          break;
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1; TX_IDLE = 1'b1; u_idle = 1'b1; u_seen = 0; u_left = 0;
    prev_grant = '0; prev_dr = 1'b0; prev_data = '0; hs = '0;
    REQ_VALID = '0; REQ_LAST = '0; REQ_DATA = '0;
    clear_test();
    do_reset(3);

    // Single byte from req0
    add_byte(0, 8'hAA, 1'b1);
    drive_src();
    wait_drain(200);
    check_eq("single_xfer", 32'(n_xfer[0]), 1);
    check_eq("single_ready_pulses", 32'(rdy_hi[0]), 1);
    check_eq("single_dr_cycles", 32'(dr_max_run), 3);
    check_eq("single_grant_end", 32'(GRANT), 0);
    exp_bytes.push_back(8'hAA);
    exp_grants.push_back(0);
    check_stream("single");

    // ptr must now be 1: req1 beats req0
    clear_logs();
    add_byte(0, 8'h01, 1'b1);
    add_byte(1, 8'h02, 1'b1);
    drive_src();
    wait_drain(300);
    exp_bytes.push_back(8'h02); exp_bytes.push_back(8'h01);
    exp_grants.push_back(1);    exp_grants.push_back(0);
    check_stream("ptr_after_single");

    // Round robin over req0, req1, req3
    clear_test();
    do_reset(2);
    add_byte(0, 8'h10, 1'b1); add_byte(0, 8'h11, 1'b1);
    add_byte(1, 8'h20, 1'b1); add_byte(1, 8'h21, 1'b1);
    add_byte(3, 8'h30, 1'b1); add_byte(3, 8'h31, 1'b1);
    drive_src();
    wait_drain(1000);
    exp_grants = '{0, 1, 3, 0, 1, 3};
    exp_bytes  = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};
    check_stream("round_robin");

    // Packet lock: req2 three-byte packet, req0 waiting throughout
    clear_test();
    do_reset(2);
    add_byte(2, 8'h4C, 1'b0); add_byte(2, 8'h11, 1'b0); add_byte(2, 8'h22, 1'b1);
    drive_src();
    n = 0;
    while (n_xfer[2] == 0 && n < 20) begin step(); n++; end
    check_eq("lock_first_xfer", 32'(n_xfer[2]), 1);
    add_byte(0, 8'h55, 1'b1);
    drive_src();
    wait_drain(500);
    exp_grants = '{2, 0};
    exp_bytes  = '{8'h4C, 8'h11, 8'h22, 8'h55};
    check_stream("packet_lock");
    check_eq("lock_req0_ready", 32'(rdy_hi[0]), 1);

    // Timeout: transmitter never leaves idle
    clear_test();
    do_reset(2);
    ack_dly = 1000;
    add_byte(1, 8'h31, 1'b1);
    drive_src();
    n = 0;
    while (!TIMEOUT_ERR && n < 40) begin step(); n++; end
    check_eq("to_err_seen", 32'(TIMEOUT_ERR), 1);
    check_eq("to_dr_cycles", 32'(dr_max_run), ACK_TO);
    check_eq("to_busy", 32'(BUSY), 0);
    ack_dly = 2;
    add_byte(0, 8'h30, 1'b1);
    add_byte(2, 8'h32, 1'b1);
    drive_src();
    wait_drain(500);
    check_eq("to_err_cycles", 32'(terr_cyc), 1);
    check_eq("to_req1_consumed", 32'(n_xfer[1]), 1);
    exp_grants = '{1, 2, 0};
    exp_bytes  = '{8'h32, 8'h30};
    check_stream("timeout");

    // Accept on the same cycle the counter reaches ACK_TIMEOUT
    clear_test();
    do_reset(2);
    ack_dly = ACK_TO - 1;
    add_byte(0, 8'h5A, 1'b1);
    drive_src();
    n = 0;
    while (!TX_DATA_READY && n < 10) begin step(); n++; end
    n = 0;
    while (TX_DATA_READY && n < 20) begin step(); n++; end
    check_eq("tie_no_err", 32'(TIMEOUT_ERR), 0);
    check_eq("tie_grant_held", 32'(GRANT), 32'h1);
    check_eq("tie_busy", 32'(BUSY), 1);
    wait_drain(200);
    check_eq("tie_err_cycles", 32'(terr_cyc), 0);
    check_eq("tie_dr_cycles", 32'(dr_max_run), ACK_TO);
    exp_grants = '{0};
    exp_bytes  = '{8'h5A};
    check_stream("tie");

    // Reset while in DONE of byte 2 of a 3-byte packet
    clear_test();
    do_reset(2);
    ack_dly = 1;
    frame_len = 10;
    add_byte(1, 8'h61, 1'b0); add_byte(1, 8'h62, 1'b0); add_byte(1, 8'h63, 1'b1);
    drive_src();
    n = 0;
    while (!(sent_q.size() == 2 && !TX_DATA_READY) && n < 100) begin step(); n++; end
    check_eq("mid_two_sent", 32'(sent_q.size()), 2);
    check_eq("mid_in_done", 32'(BUSY), 1);
    do_reset(1);
    clear_logs();
    add_byte(0, 8'h70, 1'b1);
    drive_src();
    wait_drain(500);
    exp_grants = '{0, 1};
    exp_bytes  = '{8'h70, 8'h63};
    check_stream("reset_mid");

    // Randomized rounds against the packet-level model
    for (int r = 0; r < 8; r++) begin
      clear_test();
      do_reset(2);
      rand_timing = 1;
      ack_dly   = int'($urandom_range(0, ACK_TO - 1));
      frame_len = int'($urandom_range(1, 6));
      for (int i = 0; i < N; i++) begin
        int np;
        np = int'($urandom_range(0, 3));
        for (int p = 0; p < np; p++) begin
          int len;
          len = int'($urandom_range(1, 3));
          for (int b = 0; b < len; b++)
            add_byte(i, 8'(((i & 3) << 6) | int'($urandom_range(0, 63))), (b == len - 1));
        end
      end
      drive_src();
      model_rr();
      wait_drain(3000);
      check_stream("random");
      check_eq("random_no_err", 32'(terr_cyc), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
